// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD registered read ports, two prioritised write ports,
// and a one-register-per-cycle clear sweep after reset with a busy flag.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic                       busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic ZR = (ZERO_REG != 0);

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [ADDR_W-1:0]          r_ptr;
  logic [ADDR_W-1:0]          w_ptr_nxt;
  logic                       r_busy;
  logic [NUM_RD*DATA_W-1:0]   r_rdata;
  logic [NUM_RD*DATA_W-1:0]   w_rdata_nxt;
  logic [DATA_W-1:0]          r_regs [DEPTH];
  logic                       w_clr_en;
  logic                       w_ready;
  logic                       w_wr0;
  logic                       w_wr1;
  logic [ADDR_W-1:0]          w_ra;

  // Writes to register 0 vanish entirely when it is hardwired, including for bypass.
  assign w_wr0 = we0 && w_ready && !(ZR && (waddr0 == {ADDR_W{1'b0}}));
  assign w_wr1 = we1 && w_ready && !(ZR && (waddr1 == {ADDR_W{1'b0}}));

  // State register: sweep pointer, state and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_ptr   <= {ADDR_W{1'b0}};
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= (w_state_nxt == ST_CLEAR);
    end
  end

  // Next-state logic: walk the pointer once over the array, then settle in READY.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_CLEAR: begin
        w_ptr_nxt = r_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (r_ptr == LAST_ADDR) begin
          w_state_nxt = ST_READY;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_ptr_nxt   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Output decode of the state.
  always_comb begin
    case (r_state)
      ST_CLEAR: begin
        w_clr_en = 1'b1;
        w_ready  = 1'b0;
      end
      ST_READY: begin
        w_clr_en = 1'b0;
        w_ready  = 1'b1;
      end
      default: begin
        w_clr_en = 1'b0;
        w_ready  = 1'b0;
      end
    endcase
  end

  // Array update; port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst && w_clr_en) begin
      r_regs[r_ptr] <= {DATA_W{1'b0}};
    end else if (!rst) begin
      if (w_wr0) begin
        r_regs[waddr0] <= wdata0;
      end
      if (w_wr1) begin
        r_regs[waddr1] <= wdata1;
      end
    end
  end

  // Per-port read mux with zero-register, write-port bypass and array fallback.
  always_comb begin
    w_rdata_nxt = {(NUM_RD*DATA_W){1'b0}};
    w_ra        = {ADDR_W{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      w_ra = raddr[i*ADDR_W +: ADDR_W];
      if (!w_ready) begin
        w_rdata_nxt[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if (ZR && (w_ra == {ADDR_W{1'b0}})) begin
        w_rdata_nxt[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if (w_wr1 && (waddr1 == w_ra)) begin
        w_rdata_nxt[i*DATA_W +: DATA_W] = wdata1;
      end else if (w_wr0 && (waddr0 == w_ra)) begin
        w_rdata_nxt[i*DATA_W +: DATA_W] = wdata0;
      end else begin
        w_rdata_nxt[i*DATA_W +: DATA_W] = r_regs[w_ra];
      end
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= {(NUM_RD*DATA_W){1'b0}};
    end else begin
      r_rdata <= w_rdata_nxt;
    end
  end

  assign rdata = r_rdata;
  assign busy  = r_busy;

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port general-purpose register file, the successor to the single-write/two-read pipeline register file. Sits between decode (read ports) and writeback (write ports). Adds a configurable read-port count and two write ports with defined priority. Also adds a sequential hardware clear sweep after reset, with a busy flag that stalls the pipeline until every register holds zero.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports, legal range 1..4
ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is an ordinary register

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
we0  in  1  write enable, write port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, write port 1 (higher priority)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
raddr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  packed registered read data; port i = bits [i*DATA_W +: DATA_W]
busy  out  1  high while the clear sweep runs; writes are ignored while busy is high

Behaviour:
- Reset: clk and rst are fixed; reset is synchronous, active-high.
- On a rising edge with rst=1:
  - state <= CLEAR, clear pointer <= 0, busy <= 1, all rdata <= 0.
  - Array contents are not touched in that cycle.
- State machine has two states, CLEAR and READY.
- CLEAR, each edge with rst=0:
  - regs[ptr] <= 0, ptr <= ptr+1.
  - we0/we1 are ignored.
  - rdata <= 0 for every port.
  - When ptr == DEPTH-1, that register is cleared, state <= READY and busy <= 0 on the same edge.
  - busy is therefore high for exactly DEPTH edges after rst falls.
- READY: normal operation; stays READY until rst.
- rst asserted mid-sweep or in READY returns to CLEAR with ptr=0 and restarts the full sweep.
- Writes (READY only) commit on the rising edge.
  - If we0 and we1 target the same address, wdata1 is stored and wdata0 is discarded.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads: 1-cycle latency. rdata port i at edge k reflects raddr[i] sampled at edge k. Priority per port:
  1. ZERO_REG=1 and raddr[i]==0 -> 0.
  2. Bypass from port 1 (we1 && waddr1==raddr[i]) -> wdata1.
  3. Bypass from port 0 (we0 && waddr0==raddr[i]) -> wdata0.
  4. Otherwise -> regs[raddr[i]].
- Bypass rules:
  - Bypass applies only in READY.
  - Bypass never returns data for a dropped write (address 0 with ZERO_REG=1).
- Read ports are fully independent. Any number of ports may read the same address in the same cycle.
- rdata holds its value across cycles only through re-sampling; there is no read enable, so rdata updates every edge.
- Widths: addresses compared at full ADDR_W; no truncation or sign handling; data passes through unchanged.
- Array has no reset value of its own; only the sweep defines contents. Reads before sweep completion return 0 via the CLEAR rule.

Test Plan:
1. Reset then sweep: rst=1 for 2 edges, then 0 (ADDR_W=5) -> busy=1 for exactly 32 edges after rst falls, then 0; reading every address then returns 0x00000000.
2. Basic write/read: in READY, we0=1, waddr0=3, wdata0=0xDEADBEEF; next cycle raddr port0=3 -> rdata port0=0xDEADBEEF one edge later.
3. Same-cycle bypass and priority: we0=1 addr 7 data 0x11111111, we1=1 addr 7 data 0x22222222, raddr port0=7 same cycle -> rdata port0=0x22222222 after that edge; a later read of 7 returns 0x22222222.
4. Zero register: ZERO_REG=1, we1=1 waddr1=0 wdata1=0xFFFFFFFF, raddr port1=0 same cycle -> rdata port1=0, and 0 on later reads. With ZERO_REG=0, the same stimulus reads back 0xFFFFFFFF.
5. Write during CLEAR ignored and reset mid-sweep:
   - Stimulus: write 0xA5A5A5A5 to address 31 at sweep edge 5; assert rst at sweep edge 10.
   - Required: busy restarts and stays high a further 32 edges after rst falls; address 31 reads 0.
6. Multi-port (NUM_RD=4): preload regs 1..4 with 0x1..0x4, read addresses {4,3,2,1} on ports 0..3 -> rdata ports 0..3 = 0x4, 0x3, 0x2, 0x1 together one edge later.
